// File: rtl/ex_mem_pipe_reg_pkg.sv
// ex_mem_pipe_reg_pkg: shared widths, opcode constant and control bundle for the EX/MEM stage register
package ex_mem_pipe_reg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic [3:0] OP_PADDSB = 4'b0111;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic halt;
    } ctrl_t;

    // An invalid instruction carries no side effects into MEM
    function automatic ctrl_t gate_ctrl(input ctrl_t c);
        return c.valid ? c : '0;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_pipe_dff.sv
// pipe_dff: width-parameterised stage register with sync reset, clear and hold (reset > clear > hold)
module pipe_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (!hold)
            q <= d;
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with PSA overflow history and MEM-to-EX forward match
module ex_mem_pipe_reg
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_halt,
    input  logic              ex_is_psa,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_psa_err,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic              mem_valid,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_halt,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_psa_err,
    output logic              psa_ovfl_sticky,
    output logic [CNT_W-1:0]  psa_ovfl_cnt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit
);

    ctrl_t            ex_ctrl;
    ctrl_t            mem_ctrl;
    logic             hold;
    logic             load;
    logic             psa_err_in;
    logic             psa_ev;
    logic             fwd_src;
    logic [CNT_W-1:0] cnt_next;

    // A loaded halt freezes the stage until reset or flush
    always_comb begin
        ex_ctrl    = gate_ctrl({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt});
        hold       = stall | mem_ctrl.halt;
        load       = ~flush & ~hold;
        psa_err_in = ex_valid & ex_is_psa & ex_psa_err;
        psa_ev     = load & psa_err_in;
        cnt_next   = (&psa_ovfl_cnt) ? psa_ovfl_cnt : psa_ovfl_cnt + CNT_W'(1);
        fwd_src    = mem_valid & mem_regwrite & ~mem_memread & (|mem_rd);
    end

    pipe_dff #(.W($bits(ctrl_t))) u_ctrl (
        .clk(clk), .rst(rst), .clr(flush), .hold(hold),
        .d(ex_ctrl), .q(mem_ctrl)
    );

    pipe_dff #(.W(1)) u_psa_err (
        .clk(clk), .rst(rst), .clr(flush), .hold(hold),
        .d(psa_err_in), .q(mem_psa_err)
    );

    pipe_dff #(.W(DATA_W)) u_result (
        .clk(clk), .rst(rst), .clr(flush), .hold(hold),
        .d(ex_result), .q(mem_result)
    );

    pipe_dff #(.W(DATA_W)) u_store (
        .clk(clk), .rst(rst), .clr(flush), .hold(hold),
        .d(ex_store_data), .q(mem_store_data)
    );

    pipe_dff #(.W(REG_W)) u_rd (
        .clk(clk), .rst(rst), .clr(flush), .hold(hold),
        .d(ex_rd), .q(mem_rd)
    );

    // Overflow history survives flushes; only reset clears it
    pipe_dff #(.W(1)) u_sticky (
        .clk(clk), .rst(rst), .clr(1'b0), .hold(~psa_ev),
        .d(1'b1), .q(psa_ovfl_sticky)
    );

    pipe_dff #(.W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .hold(~psa_ev),
        .d(cnt_next), .q(psa_ovfl_cnt)
    );

    assign mem_valid    = mem_ctrl.valid;
    assign mem_regwrite = mem_ctrl.regwrite;
    assign mem_memread  = mem_ctrl.memread;
    assign mem_memwrite = mem_ctrl.memwrite;
    assign mem_halt     = mem_ctrl.halt;
    assign fwd_rs_hit   = fwd_src & (mem_rd == id_rs);
    assign fwd_rt_hit   = fwd_src & (mem_rd == id_rt);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed and randomized checks of ex_mem_pipe_reg against a rule-level model
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt, ex_is_psa, ex_psa_err;
    logic [15:0] ex_result, ex_store_data;
    logic [3:0]  ex_rd, id_rs, id_rt;
    logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_halt, mem_psa_err;
    logic [15:0] mem_result, mem_store_data;
    logic [3:0]  mem_rd;
    logic        psa_ovfl_sticky;
    logic [7:0]  psa_ovfl_cnt;
    logic        fwd_rs_hit, fwd_rt_hit;

    int checks = 0;
    int errors = 0;

    // reference state
    bit e_valid, e_rw, e_mr, e_mw, e_halt, e_err, e_sticky;
    int e_res, e_sd, e_rd, e_cnt;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_halt(ex_halt), .ex_is_psa(ex_is_psa),
        .ex_result(ex_result), .ex_psa_err(ex_psa_err), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_halt(mem_halt), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_psa_err(mem_psa_err),
        .psa_ovfl_sticky(psa_ovfl_sticky), .psa_ovfl_cnt(psa_ovfl_cnt),
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            {e_valid, e_rw, e_mr, e_mw, e_halt, e_err, e_sticky} = '0;
            e_res = 0; e_sd = 0; e_rd = 0; e_cnt = 0;
        end else if (flush) begin
            {e_valid, e_rw, e_mr, e_mw, e_halt, e_err} = '0;
            e_res = 0; e_sd = 0; e_rd = 0;
        end else if (!stall && !e_halt) begin
            e_valid = ex_valid;
            e_rw    = ex_valid && ex_regwrite;
            e_mr    = ex_valid && ex_memread;
            e_mw    = ex_valid && ex_memwrite;
            e_halt  = ex_valid && ex_halt;
            e_err   = ex_valid && ex_is_psa && ex_psa_err;
            e_res   = int'(ex_result);
            e_sd    = int'(ex_store_data);
            e_rd    = int'(ex_rd);
            if (e_err) begin
                e_sticky = 1;
                e_cnt    = (e_cnt < 255) ? e_cnt + 1 : 255;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit src;
        src = e_valid && e_rw && !e_mr && e_rd != 0;
        chk({tag, ".valid"},  32'(mem_valid),       32'(e_valid));
        chk({tag, ".rw"},     32'(mem_regwrite),    32'(e_rw));
        chk({tag, ".mr"},     32'(mem_memread),     32'(e_mr));
        chk({tag, ".mw"},     32'(mem_memwrite),    32'(e_mw));
        chk({tag, ".halt"},   32'(mem_halt),        32'(e_halt));
        chk({tag, ".err"},    32'(mem_psa_err),     32'(e_err));
        chk({tag, ".res"},    32'(mem_result),      32'(e_res));
        chk({tag, ".sd"},     32'(mem_store_data),  32'(e_sd));
        chk({tag, ".rd"},     32'(mem_rd),          32'(e_rd));
        chk({tag, ".sticky"}, 32'(psa_ovfl_sticky), 32'(e_sticky));
        chk({tag, ".cnt"},    32'(psa_ovfl_cnt),    32'(e_cnt));
        chk({tag, ".fwd_rs"}, 32'(fwd_rs_hit),      32'(src && e_rd == int'(id_rs)));
        chk({tag, ".fwd_rt"}, 32'(fwd_rt_hit),      32'(src && e_rd == int'(id_rt)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_ex();
        ex_valid      = $urandom_range(0, 3) != 0;
        ex_regwrite   = 1'($urandom);
        ex_memread    = 1'($urandom);
        ex_memwrite   = 1'($urandom);
        ex_halt       = $urandom_range(0, 24) == 0;
        ex_is_psa     = 1'($urandom);
        ex_psa_err    = 1'($urandom);
        ex_result     = 16'($urandom);
        ex_store_data = 16'($urandom);
        ex_rd         = 4'($urandom);
        id_rs         = $urandom_range(0, 1) ? 4'(e_rd) : 4'($urandom);
        id_rt         = $urandom_range(0, 1) ? 4'(e_rd) : 4'($urandom);
    endtask

    task automatic set_ex(input bit v, rw, mr, mw, h, psa, err, input logic [15:0] res, input logic [3:0] rd);
        ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_halt = h;
        ex_is_psa = psa; ex_psa_err = err; ex_result = res; ex_store_data = ~res; ex_rd = rd;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id_rs = '0; id_rt = '0;
        rand_ex();
        tick("reset0");
        tick("reset1");
        rst = 1'b0;

        // PSA overflow load
        set_ex(1, 1, 0, 0, 0, 1, 1, 16'h7777, 4'h5);
        tick("psa_load");
        chk("psa_res", 32'(mem_result), 32'h7777);
        chk("psa_err", 32'(mem_psa_err), 32'h1);
        chk("psa_cnt", 32'(psa_ovfl_cnt), 32'h1);

        // overflow flag on a non-PSA instruction is ignored
        set_ex(1, 1, 0, 0, 0, 0, 1, 16'h1234, 4'h6);
        tick("nonpsa");
        chk("nonpsa_err", 32'(mem_psa_err), 32'h0);
        chk("nonpsa_cnt", 32'(psa_ovfl_cnt), 32'h1);

        // stall holds everything, then flush inside stall makes a bubble
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            ex_is_psa = 1'b1; ex_psa_err = 1'b1; ex_valid = 1'b1;
            tick("stall");
        end
        chk("stall_res", 32'(mem_result), 32'h1234);
        flush = 1'b1;
        tick("flush_stall");
        chk("flush_valid", 32'(mem_valid), 32'h0);
        chk("flush_res", 32'(mem_result), 32'h0);
        stall = 1'b0; flush = 1'b0;

        // forwarding compare cases
        set_ex(1, 1, 0, 0, 0, 0, 0, 16'h00aa, 4'h3);
        id_rs = 4'h3; id_rt = 4'h0;
        tick("fwd_hit");
        chk("fwd_rs1", 32'(fwd_rs_hit), 32'h1);
        chk("fwd_rt0", 32'(fwd_rt_hit), 32'h0);
        set_ex(1, 1, 0, 0, 0, 0, 0, 16'h00bb, 4'h0);
        id_rs = 4'h0; id_rt = 4'h0;
        tick("fwd_r0");
        chk("fwd_r0_rs", 32'(fwd_rs_hit), 32'h0);
        set_ex(1, 1, 1, 0, 0, 0, 0, 16'h00cc, 4'h3);
        id_rs = 4'h3; id_rt = 4'h3;
        tick("fwd_load");
        chk("fwd_ld_rs", 32'(fwd_rs_hit), 32'h0);
        set_ex(0, 1, 0, 0, 0, 0, 0, 16'h00dd, 4'h3);
        tick("fwd_invalid");

        // halt freezes the stage; reset during halt clears it
        set_ex(1, 1, 0, 1, 1, 0, 0, 16'h4242, 4'h7);
        tick("halt_load");
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            tick("halt_hold");
        end
        chk("halt_res", 32'(mem_result), 32'h4242);
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        tick("halt_rst");
        chk("halt_rst_h", 32'(mem_halt), 32'h0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_ex();
        tick("post_rst");

        // halt is cleared by flush as well
        set_ex(1, 0, 0, 0, 1, 0, 0, 16'h0001, 4'h1);
        tick("halt2");
        flush = 1'b1;
        tick("halt2_flush");
        flush = 1'b0;

        // counter saturation
        rst = 1'b1;
        tick("sat_rst");
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            set_ex(1, 1, 0, 0, 0, 1, 1, 16'($urandom), 4'($urandom));
            tick("sat");
        end
        chk("sat_cnt", 32'(psa_ovfl_cnt), 32'hff);
        chk("sat_sticky", 32'(psa_ovfl_sticky), 32'h1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_ex();
            rst   = $urandom_range(0, 59) == 0;
            flush = $urandom_range(0, 9) == 0;
            stall = $urandom_range(0, 5) == 0;
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 Parameter DATA_W, 16, datapath width of ALU/PSA result and store data.
REQ-002 Parameter REG_W, 4, register-specifier width.
REQ-003 Parameter CNT_W, 8, width of PSA overflow event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold all stage contents this cycle.
REQ-007 flush  input  1  load a bubble this cycle.
REQ-008 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt  input  1 each  EX-stage control bits.
REQ-009 ex_is_psa  input  1  EX instruction is PADDSB.
REQ-010 ex_result  input  DATA_W  ALU/PSA result (PSA Sum when ex_is_psa).
REQ-011 ex_psa_err  input  1  PSA overflow (OR of four nibble overflows).
REQ-012 ex_store_data  input  DATA_W  store data; ex_rd  input  REG_W  destination register.
REQ-013 id_rs, id_rt  input  REG_W each  source specifiers of the instruction now in EX (forward compare).
REQ-014 mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_halt  output  1 each  registered control.
REQ-015 mem_result, mem_store_data  output  DATA_W each; mem_rd  output  REG_W  registered fields.
REQ-016 mem_psa_err  output  1  registered PSA overflow of the held instruction.
REQ-017 psa_ovfl_sticky  output  1; psa_ovfl_cnt  output  CNT_W  overflow history.
REQ-018 fwd_rs_hit, fwd_rt_hit  output  1 each  combinational MEM-to-EX forward match.

Function
REQ-019 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on mem_* after edge N.
REQ-020 Update priority SHALL be rst > flush > stall > load.
REQ-021 Load SHALL capture every ex_* field into the matching mem_* register.
REQ-022 Stall (flush=0) SHALL hold every register, including sticky and counter.
REQ-023 Flush SHALL clear mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_halt, mem_psa_err; data fields and mem_rd SHALL be cleared to 0; flush during stall SHALL still insert the bubble.
REQ-024 mem_psa_err SHALL load ex_psa_err & ex_is_psa & ex_valid; non-PSA instructions SHALL load 0.
REQ-025 psa_ovfl_sticky SHALL set on any load with ex_valid & ex_is_psa & ex_psa_err and clear only on rst.
REQ-026 psa_ovfl_cnt SHALL increment by 1 on each such load and saturate at 2^CNT_W-1 (no wrap).
REQ-027 Flushed or stalled cycles SHALL not update sticky or counter, even if ex_psa_err=1.
REQ-028 fwd_rs_hit SHALL be mem_valid & mem_regwrite & ~mem_memread & (mem_rd != 0) & (mem_rd == id_rs); fwd_rt_hit likewise with id_rt.
REQ-029 Once mem_halt=1 is loaded, the stage SHALL hold (ignore load) until rst; flush SHALL still clear it.
REQ-030 Control inputs with ex_valid=0 SHALL load as 0 (bubble), data fields loaded as presented.

Reset
REQ-031 On rst at an edge, all mem_* outputs, psa_ovfl_sticky and psa_ovfl_cnt SHALL become 0; reset overrides flush and stall.
REQ-032 Reset asserted mid-stall or while halted SHALL clear state on that edge; first load occurs the edge after rst deasserts.

Structure
REQ-033 Shared package SHALL hold DATA_W, REG_W, CNT_W defaults, the PADDSB opcode constant and a control-bundle typedef (valid, regwrite, memread, memwrite, halt).
REQ-034 One sub-module, pipe_dff (parameterised-width register with rst, clr, hold), SHALL implement all field storage.
REQ-035 Counter saturation and forward compare SHALL reside in the top module.

Verification
REQ-036 ex_result=16'h7777, ex_is_psa=1, ex_psa_err=1, valid, load -> next cycle mem_result=16'h7777, mem_psa_err=1, sticky=1, cnt=1.
REQ-037 stall=1 three cycles with changing inputs -> all outputs unchanged; then flush=1 with stall=1 -> mem_valid=0, mem_result=0.
REQ-038 Preload cnt to 255 via 255 overflow loads, one more overflow load -> cnt stays 255, sticky=1.
REQ-039 mem_rd=4'h3, regwrite=1, memread=0, id_rs=3, id_rt=0 -> fwd_rs_hit=1, fwd_rt_hit=0; mem_rd=0 -> both 0; memread=1 -> both 0.
REQ-040 Load halt=1 then new inputs -> outputs hold; rst=1 during halt -> all outputs 0 next edge.
REQ-041 ex_psa_err=1 with ex_is_psa=0 -> mem_psa_err=0, sticky and cnt unchanged.
